// File: rtl/xbar_bridge_pkg.sv
// Shared types and helpers for the round-robin address-decoded bridge.
// Struct field widths track the bridge's default data-path widths.
package xbar_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned AUX_W  = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [AUX_W-1:0]  aux;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              opc;
        logic [AUX_W-1:0]  aux;
    } resp_t;

    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    // Unmapped addresses decode to a virtual slave one past the last real one.
    function automatic int unsigned err_target(input int unsigned n_slave);
        return n_slave;
    endfunction

endpackage

// File: rtl/xbar_bridge_rr_arb.sv
// Round-robin arbiter for one slave port; the pointer only advances when the
// winner's request is actually accepted by the slave.
module rr_arbiter_bridge
    import xbar_bridge_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         gnt_i,
    output logic [N-1:0] win_oh_o
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx, idx;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end

        win_oh_o = '0;
        if (found) begin
            win_oh_o[win_idx] = 1'b1;
        end

        ptr_d = ptr_q;
        if (found && gnt_i) begin
            ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xbar_bridge_rr.sv
// Address-decoded N-master to N-slave bridge with per-slave round-robin,
// per-master outstanding limit, destination lock and an internal error responder.
module xbar_bridge_rr
    import xbar_bridge_pkg::*;
#(
    parameter int unsigned N_MASTER        = 9,
    parameter int unsigned N_SLAVE         = 3,
    parameter int unsigned ADDR_WIDTH      = ADDR_W,
    parameter int unsigned DATA_WIDTH      = DATA_W,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned AUX_WIDTH       = AUX_W,
    parameter int unsigned ID_WIDTH        = N_MASTER,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_MASTER-1:0]                   data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]   data_add_i,
    input  logic [N_MASTER-1:0]                   data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]     data_be_i,
    input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]    data_aux_i,
    output logic [N_MASTER-1:0]                   data_gnt_o,
    output logic [N_MASTER-1:0]                   data_r_valid_o,
    output logic [N_MASTER-1:0][DATA_WIDTH-1:0]   data_r_rdata_o,
    output logic [N_MASTER-1:0]                   data_r_opc_o,
    output logic [N_MASTER-1:0][AUX_WIDTH-1:0]    data_r_aux_o,
    output logic [N_SLAVE-1:0]                    data_req_o,
    output logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]    data_add_o,
    output logic [N_SLAVE-1:0]                    data_wen_o,
    output logic [N_SLAVE-1:0][DATA_WIDTH-1:0]    data_wdata_o,
    output logic [N_SLAVE-1:0][BE_WIDTH-1:0]      data_be_o,
    output logic [N_SLAVE-1:0][AUX_WIDTH-1:0]     data_aux_o,
    output logic [N_SLAVE-1:0][ID_WIDTH-1:0]      data_ID_o,
    input  logic [N_SLAVE-1:0]                    data_gnt_i,
    input  logic [N_SLAVE-1:0]                    data_r_valid_i,
    input  logic [N_SLAVE-1:0][ID_WIDTH-1:0]      data_r_ID_i,
    input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]    data_r_rdata_i,
    input  logic [N_SLAVE-1:0]                    data_r_opc_i,
    input  logic [N_SLAVE-1:0][AUX_WIDTH-1:0]     data_r_aux_i,
    input  logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]    START_ADDR,
    input  logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]    END_ADDR
);

    localparam int unsigned   CW      = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned   TW      = $clog2(N_SLAVE + 1);
    localparam logic [TW-1:0] TGT_ERR = TW'(err_target(N_SLAVE));
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [N_MASTER-1:0][TW-1:0]        tgt, dest_q, dest_d;
    logic [N_MASTER-1:0][CW-1:0]        cnt_q, cnt_d;
    logic [N_MASTER-1:0]                elig, err_hs, hs;
    logic [N_MASTER-1:0]                err_valid_q, err_valid_d;
    logic [N_MASTER-1:0][AUX_WIDTH-1:0] err_aux_q, err_aux_d;
    logic [N_SLAVE-1:0][N_MASTER-1:0]   arb_req, win_oh;
    logic [N_MASTER-1:0][N_SLAVE:0]     src_hit;
    logic [N_MASTER-1:0]                rsp_valid;
    req_t  [N_SLAVE-1:0]                slv_req;
    resp_t [N_MASTER-1:0]               mst_rsp;

    // Decode walks slaves downwards so the lowest matching index wins on overlap.
    always_comb begin
        for (int m = 0; m < int'(N_MASTER); m++) begin
            tgt[m] = TGT_ERR;
            for (int s = int'(N_SLAVE) - 1; s >= 0; s--) begin
                if (data_add_i[m] >= START_ADDR[s] && data_add_i[m] < END_ADDR[s]) begin
                    tgt[m] = TW'(s);
                end
            end
            elig[m]   = data_req_i[m] && (cnt_q[m] < CNT_MAX) &&
                        ((cnt_q[m] == '0) || (tgt[m] == dest_q[m]));
            err_hs[m] = elig[m] && (tgt[m] == TGT_ERR);
            for (int s = 0; s < int'(N_SLAVE); s++) begin
                arb_req[s][m] = elig[m] && (tgt[m] == TW'(s));
            end
        end
    end

    for (genvar s = 0; s < int'(N_SLAVE); s++) begin : g_slv
        rr_arbiter_bridge #(.N(N_MASTER)) u_arb (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_i    (arb_req[s]),
            .gnt_i    (data_gnt_i[s]),
            .win_oh_o (win_oh[s])
        );
    end

    always_comb begin
        for (int s = 0; s < int'(N_SLAVE); s++) begin
            slv_req[s] = '0;
            for (int m = 0; m < int'(N_MASTER); m++) begin
                if (win_oh[s][m]) begin
                    slv_req[s].add   = data_add_i[m];
                    slv_req[s].wen   = data_wen_i[m];
                    slv_req[s].wdata = data_wdata_i[m];
                    slv_req[s].be    = data_be_i[m];
                    slv_req[s].aux   = data_aux_i[m];
                end
            end
            data_req_o[s]   = |arb_req[s];
            data_ID_o[s]    = win_oh[s];
            data_add_o[s]   = slv_req[s].add;
            data_wen_o[s]   = slv_req[s].wen;
            data_wdata_o[s] = slv_req[s].wdata;
            data_be_o[s]    = slv_req[s].be;
            data_aux_o[s]   = slv_req[s].aux;
        end
    end

    // Responses are only delivered to masters with something in flight, which
    // also drops stale slave responses that arrive after a reset.
    always_comb begin
        for (int m = 0; m < int'(N_MASTER); m++) begin
            data_gnt_o[m] = err_hs[m];
            for (int s = 0; s < int'(N_SLAVE); s++) begin
                data_gnt_o[m] = data_gnt_o[m] | (win_oh[s][m] & data_gnt_i[s]);
            end

            src_hit[m]          = '0;
            src_hit[m][N_SLAVE] = err_valid_q[m];
            mst_rsp[m]          = '0;
            if (err_valid_q[m]) begin
                mst_rsp[m].opc = 1'b1;
                mst_rsp[m].aux = err_aux_q[m];
            end
            for (int s = 0; s < int'(N_SLAVE); s++) begin
                if (data_r_valid_i[s] && data_r_ID_i[s][m]) begin
                    src_hit[m][s]    = 1'b1;
                    mst_rsp[m].rdata = data_r_rdata_i[s];
                    mst_rsp[m].opc   = data_r_opc_i[s];
                    mst_rsp[m].aux   = data_r_aux_i[s];
                end
            end

            rsp_valid[m]      = (|src_hit[m]) && (cnt_q[m] != '0);
            data_r_valid_o[m] = rsp_valid[m];
            data_r_rdata_o[m] = rsp_valid[m] ? mst_rsp[m].rdata : '0;
            data_r_opc_o[m]   = rsp_valid[m] ? mst_rsp[m].opc   : 1'b0;
            data_r_aux_o[m]   = rsp_valid[m] ? mst_rsp[m].aux   : '0;
        end
    end

    always_comb begin
        for (int m = 0; m < int'(N_MASTER); m++) begin
            hs[m]          = data_req_i[m] & data_gnt_o[m];
            dest_d[m]      = hs[m] ? tgt[m] : dest_q[m];
            err_valid_d[m] = err_hs[m];
            err_aux_d[m]   = err_hs[m] ? data_aux_i[m] : err_aux_q[m];
            case ({hs[m], rsp_valid[m]})
                2'b10:   cnt_d[m] = cnt_q[m] + 1'b1;
                2'b01:   cnt_d[m] = (cnt_q[m] == '0) ? '0 : cnt_q[m] - 1'b1;
                default: cnt_d[m] = cnt_q[m];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dest_q      <= '0;
            err_valid_q <= '0;
            err_aux_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dest_q      <= dest_d;
            err_valid_q <= err_valid_d;
            err_aux_q   <= err_aux_d;
        end
    end

    // The destination lock should make two simultaneous response sources impossible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < int'(N_MASTER); m++) begin
                assert ($onehot0(src_hit[m]));
            end
        end
    end

endmodule

// File: tb/tb_xbar_bridge_rr.sv
// Directed self-checking bench for xbar_bridge_rr.
module tb_xbar_bridge_rr;

    localparam int NM = 9;
    localparam int NS = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NM-1:0]        data_req_i;
    logic [NM-1:0][31:0]  data_add_i;
    logic [NM-1:0]        data_wen_i;
    logic [NM-1:0][31:0]  data_wdata_i;
    logic [NM-1:0][3:0]   data_be_i;
    logic [NM-1:0][7:0]   data_aux_i;
    logic [NM-1:0]        data_gnt_o;
    logic [NM-1:0]        data_r_valid_o;
    logic [NM-1:0][31:0]  data_r_rdata_o;
    logic [NM-1:0]        data_r_opc_o;
    logic [NM-1:0][7:0]   data_r_aux_o;
    logic [NS-1:0]        data_req_o;
    logic [NS-1:0][31:0]  data_add_o;
    logic [NS-1:0]        data_wen_o;
    logic [NS-1:0][31:0]  data_wdata_o;
    logic [NS-1:0][3:0]   data_be_o;
    logic [NS-1:0][7:0]   data_aux_o;
    logic [NS-1:0][NM-1:0] data_ID_o;
    logic [NS-1:0]        data_gnt_i;
    logic [NS-1:0]        data_r_valid_i;
    logic [NS-1:0][NM-1:0] data_r_ID_i;
    logic [NS-1:0][31:0]  data_r_rdata_i;
    logic [NS-1:0]        data_r_opc_i;
    logic [NS-1:0][7:0]   data_r_aux_i;
    logic [NS-1:0][31:0]  START_ADDR;
    logic [NS-1:0][31:0]  END_ADDR;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_w;

    xbar_bridge_rr dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
        .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_aux_i(data_aux_i),
        .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
        .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o), .data_r_aux_o(data_r_aux_o),
        .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_aux_o(data_aux_o),
        .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
        .data_r_ID_i(data_r_ID_i), .data_r_rdata_i(data_r_rdata_i), .data_r_opc_i(data_r_opc_i),
        .data_r_aux_i(data_r_aux_i), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        data_req_i     = '0;
        data_add_i     = '0;
        data_wen_i     = '0;
        data_wdata_i   = '0;
        data_be_i      = '0;
        data_aux_i     = '0;
        data_gnt_i     = '0;
        data_r_valid_i = '0;
        data_r_ID_i    = '0;
        data_r_rdata_i = '0;
        data_r_opc_i   = '0;
        data_r_aux_i   = '0;
    endtask

    task automatic set_map();
        START_ADDR[0] = 32'h0000_0000; END_ADDR[0] = 32'h1000_0000;
        START_ADDR[1] = 32'h1000_0000; END_ADDR[1] = 32'h2000_0000;
        START_ADDR[2] = 32'h2000_0000; END_ADDR[2] = 32'h3000_0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        set_map();
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt",    64'(data_gnt_o), 64'h0);
        check("rst_rvalid", 64'(data_r_valid_o), 64'h0);
        check("rst_req",    64'(data_req_o), 64'h0);
        check("rst_id",     64'(data_ID_o), 64'h0);
        check("rst_opc",    64'(data_r_opc_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin between masters 0 and 3 on slave 1.
        data_req_i[0] = 1'b1; data_add_i[0] = 32'h1000_0010;
        data_req_i[3] = 1'b1; data_add_i[3] = 32'h1000_0020;
        data_gnt_i[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_w = (k % 2 == 0) ? 9'h001 : 9'h008;
            check("rr_id",  64'(data_ID_o[1]), 64'(exp_w));
            check("rr_gnt", 64'(data_gnt_o), 64'(exp_w));
            check("rr_req", 64'(data_req_o), 64'h2);
            check("rr_add", 64'(data_add_o[1]), (k % 2 == 0) ? 64'h1000_0010 : 64'h1000_0020);
            @(negedge clk);
        end

        // Outstanding limit on master 2 to a silent slave 0.
        do_reset();
        data_req_i[2] = 1'b1; data_add_i[2] = 32'h0000_0040; data_gnt_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("lim_gnt", 64'(data_gnt_o[2]), 64'h1);
            @(negedge clk);
        end
        #1;
        check("lim_block_gnt", 64'(data_gnt_o[2]), 64'h0);
        check("lim_block_req", 64'(data_req_o[0]), 64'h0);
        @(negedge clk);
        data_r_valid_i[0] = 1'b1; data_r_ID_i[0] = 9'h004;
        data_r_rdata_i[0] = 32'hCAFE_0002; data_r_aux_i[0] = 8'h33;
        #1;
        check("lim_rvalid", 64'(data_r_valid_o), 64'h004);
        check("lim_rdata",  64'(data_r_rdata_o[2]), 64'hCAFE_0002);
        check("lim_raux",   64'(data_r_aux_o[2]), 64'h33);
        check("lim_ropc",   64'(data_r_opc_o[2]), 64'h0);
        check("lim_gnt_rsp_cycle", 64'(data_gnt_o[2]), 64'h0);
        @(negedge clk);
        data_r_valid_i[0] = 1'b0; data_r_ID_i[0] = '0;
        #1;
        check("lim_gnt5", 64'(data_gnt_o[2]), 64'h1);
        check("lim_rvalid_off", 64'(data_r_valid_o), 64'h0);

        // Destination lock: master 1 switches from slave 0 to slave 2.
        do_reset();
        data_req_i[1] = 1'b1; data_add_i[1] = 32'h0000_0100;
        data_gnt_i[0] = 1'b1; data_gnt_i[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("lock_gnt_s0", 64'(data_gnt_o[1]), 64'h1);
            @(negedge clk);
        end
        data_add_i[1] = 32'h2000_0000;
        #1;
        check("lock_hold_gnt", 64'(data_gnt_o[1]), 64'h0);
        check("lock_hold_req", 64'(data_req_o[2]), 64'h0);
        @(negedge clk);
        data_r_valid_i[0] = 1'b1; data_r_ID_i[0] = 9'h002; data_r_rdata_i[0] = 32'h1111;
        #1;
        check("lock_rsp1_valid", 64'(data_r_valid_o), 64'h002);
        check("lock_rsp1_gnt",   64'(data_gnt_o[1]), 64'h0);
        check("lock_rsp1_req",   64'(data_req_o[2]), 64'h0);
        @(negedge clk);
        data_r_rdata_i[0] = 32'h2222;
        #1;
        check("lock_rsp2_rdata", 64'(data_r_rdata_o[1]), 64'h2222);
        check("lock_rsp2_gnt",   64'(data_gnt_o[1]), 64'h0);
        check("lock_rsp2_req",   64'(data_req_o[2]), 64'h0);
        @(negedge clk);
        data_r_valid_i[0] = 1'b0; data_r_ID_i[0] = '0;
        #1;
        check("lock_rel_gnt", 64'(data_gnt_o[1]), 64'h1);
        check("lock_rel_req", 64'(data_req_o), 64'h4);
        check("lock_rel_id",  64'(data_ID_o[2]), 64'h002);
        check("lock_rel_add", 64'(data_add_o[2]), 64'h2000_0000);

        // Error responder for an unmapped address, back-to-back.
        do_reset();
        data_req_i[5] = 1'b1; data_add_i[5] = 32'h3000_0000; data_aux_i[5] = 8'h5A;
        #1;
        check("err_gnt",    64'(data_gnt_o), 64'h020);
        check("err_noreq",  64'(data_req_o), 64'h0);
        check("err_nordy",  64'(data_r_valid_o), 64'h0);
        @(negedge clk);
        data_aux_i[5] = 8'h22;
        #1;
        check("err_gnt2",   64'(data_gnt_o[5]), 64'h1);
        check("err_rvalid", 64'(data_r_valid_o), 64'h020);
        check("err_opc",    64'(data_r_opc_o[5]), 64'h1);
        check("err_rdata",  64'(data_r_rdata_o[5]), 64'h0);
        check("err_aux",    64'(data_r_aux_o[5]), 64'h5A);
        check("err_noreq2", 64'(data_req_o), 64'h0);
        @(negedge clk);
        data_req_i[5] = 1'b0;
        #1;
        check("err_rvalid2", 64'(data_r_valid_o), 64'h020);
        check("err_aux2",    64'(data_r_aux_o[5]), 64'h22);
        @(negedge clk);
        #1;
        check("err_idle", 64'(data_r_valid_o), 64'h0);

        // Overlapping ranges: lowest slave index wins.
        do_reset();
        START_ADDR[2] = 32'h0000_0000; END_ADDR[2] = 32'h0000_1000;
        data_req_i[4] = 1'b1; data_add_i[4] = 32'h0000_0100; data_gnt_i = 3'b111;
        #1;
        check("ovl_req", 64'(data_req_o), 64'h1);
        check("ovl_id",  64'(data_ID_o[0]), 64'h010);
        check("ovl_gnt", 64'(data_gnt_o), 64'h010);

        // Reset with three transactions in flight, then a stale response.
        do_reset();
        set_map();
        data_req_i[6] = 1'b1; data_add_i[6] = 32'h1000_0000; data_gnt_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mid_gnt", 64'(data_gnt_o[6]), 64'h1);
            @(negedge clk);
        end
        data_req_i[6] = 1'b0; data_gnt_i = '0; rst_n = 1'b0;
        #1;
        check("mid_rst_gnt",    64'(data_gnt_o), 64'h0);
        check("mid_rst_rvalid", 64'(data_r_valid_o), 64'h0);
        check("mid_rst_req",    64'(data_req_o), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        data_r_valid_i[1] = 1'b1; data_r_ID_i[1] = 9'h040; data_r_rdata_i[1] = 32'hDEAD_BEEF;
        #1;
        check("late_rvalid", 64'(data_r_valid_o), 64'h0);
        check("late_rdata",  64'(data_r_rdata_o[6]), 64'h0);
        @(negedge clk);
        data_r_valid_i = '0; data_r_ID_i = '0; data_r_rdata_i = '0;
        data_req_i[6] = 1'b1; data_add_i[6] = 32'h2000_0000; data_gnt_i[2] = 1'b1;
        #1;
        check("post_rst_gnt", 64'(data_gnt_o[6]), 64'h1);
        check("post_rst_req", 64'(data_req_o), 64'h4);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_bridge_rr.md
Name: xbar_bridge_rr

Overview:
- Next-generation address-decoded master-to-slave bridge. N_MASTER initiators connect to N_SLAVE range-mapped targets over the TCDM-style req/gnt/r_valid protocol.
- Extends the previous bridge with:
  - a round-robin arbiter per slave;
  - a per-master outstanding-transaction limit;
  - a destination lock that keeps responses in order;
  - an internal error responder for unmapped addresses.
- Sits between the cluster/DMA masters and L2 / peripheral slave ports.

Parameters:
- N_MASTER, 9, number of initiator ports.
- N_SLAVE, 3, number of range-mapped target ports (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- AUX_WIDTH, 8, sideband width; forwarded with the request and echoed with the response.
- ID_WIDTH, N_MASTER, one-hot master ID width.
- MAX_OUTSTANDING, 4, maximum in-flight transactions per master (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- data_req_i  in  N_MASTER  master request
- data_add_i  in  N_MASTER x ADDR_WIDTH  address
- data_wen_i  in  N_MASTER  0=store, 1=load
- data_wdata_i  in  N_MASTER x DATA_WIDTH  write data
- data_be_i  in  N_MASTER x BE_WIDTH  byte enable
- data_aux_i  in  N_MASTER x AUX_WIDTH  request aux
- data_gnt_o  out  N_MASTER  grant to master
- data_r_valid_o  out  N_MASTER  response valid
- data_r_rdata_o  out  N_MASTER x DATA_WIDTH  read data
- data_r_opc_o  out  N_MASTER  1=error
- data_r_aux_o  out  N_MASTER x AUX_WIDTH  response aux
- data_req_o  out  N_SLAVE  slave request
- data_add_o, data_wen_o, data_wdata_o, data_be_o, data_aux_o  out  N_SLAVE x (per-field width)  forwarded request fields
- data_ID_o  out  N_SLAVE x ID_WIDTH  one-hot ID of the granted master
- data_gnt_i  in  N_SLAVE  slave grant
- data_r_valid_i  in  N_SLAVE  slave response valid
- data_r_ID_i  in  N_SLAVE x ID_WIDTH  response ID
- data_r_rdata_i  in  N_SLAVE x DATA_WIDTH  response data
- data_r_opc_i  in  N_SLAVE  response error
- data_r_aux_i  in  N_SLAVE x AUX_WIDTH  response aux
- START_ADDR, END_ADDR  in  N_SLAVE x ADDR_WIDTH  slave s owns [START_ADDR[s], END_ADDR[s])

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_n); the clock is clk.
  - On reset all counters are 0, all locks are cleared and all arbiter pointers are 0.
  - Registered outputs (error-response path) reset to 0.
  - With no requests and no responses, every combinational output is 0.
- Address decode (combinational, per master):
  - Target = lowest slave index s with START_ADDR[s] <= add < END_ADDR[s]. Unsigned compare, so an empty range (END <= START) never matches.
  - No match: target = ERR, a virtual slave index N_SLAVE.
- Eligibility: master m is eligible iff req_i[m] and cnt[m] < MAX_OUTSTANDING and (cnt[m] == 0 or target == dest_q[m]).
  - An ineligible master gets gnt_o = 0 and raises no slave request.
- Arbitration per real slave s:
  - data_req_o[s] = OR of the eligible masters targeting s.
  - Round-robin winner, starting the search at ptr[s].
  - Request fields are muxed from the winner; data_ID_o[s] = 1 << winner.
  - data_gnt_o[winner] = data_gnt_i[s], combinational, zero added latency.
  - ptr[s] <= winner+1, with wrap to 0 after N_MASTER-1, only on data_req_o[s] & data_gnt_i[s].
  - Without a grant the pointer holds; the winner stays stable only while its request stays asserted.
- ERR target:
  - Granted immediately: gnt_o = 1 in the same cycle, no arbitration needed (one per master).
  - Next cycle: data_r_valid_o[m] = 1, rdata = 0, opc = 1, aux = the aux sampled at grant.
  - Back-to-back ERR requests give back-to-back error responses.
- Bookkeeping on a request handshake (req & gnt) of master m: dest_q[m] <= target.
- Outstanding counter cnt[m], width clog2(MAX_OUTSTANDING+1):
  - +1 on a request handshake.
  - -1 on a response delivered to m.
  - Both in the same cycle: unchanged.
  - Never wraps; a response with cnt == 0 is a protocol violation (assertion, counter held at 0).
- Response routing, per master m:
  - r_valid_o[m] = OR over s of (r_valid_i[s] & r_ID_i[s][m]), OR the error-responder valid.
  - rdata, opc and aux come through a one-hot mux on the matching source.
  - The destination lock guarantees at most one source per master per cycle; this is asserted in simulation.
- Lock release: with cnt reaching 0, a request to a new target is eligible in the cycle after the last response. With a response and a new-target request in the same cycle, the request still waits one cycle.
- Reset mid-transaction: all state is cleared. Responses in flight that arrive after reset are dropped, with no r_valid_o.

Decomposition:
- Package xbar_bridge_pkg:
  - req_t / resp_t structs (add, wen, wdata, be, aux; rdata, opc, aux);
  - helper function for the outstanding-counter width;
  - constant encoding ERR = N_SLAVE.
- Sub-module rr_arbiter_bridge (N_MASTER requests, pointer register, gnt-qualified advance), instantiated once per slave.
- The error responder and per-master counter/lock stay inline.

Test Plan:
- Masters 0 and 3 both request slave 1 every cycle, data_gnt_i[1] = 1: grants alternate 0,3,0,3; data_ID_o[1] alternates 0x001, 0x008.
- MAX_OUTSTANDING = 4, slave never responds: master 2 gets 4 grants, then gnt_o = 0 while req is held. One r_valid with ID 0x004 → a 5th grant the next cycle.
- Master 1 with 2 outstanding to slave 0 issues an address in slave 2 → gnt_o = 0 until both responses return. Grant in the cycle after the second response; data_req_o[2] is never raised early.
- Address 0x3000_0000 outside all ranges, aux = 0x5A → gnt_o same cycle. Next cycle r_valid_o = 1, opc = 1, rdata = 0, aux = 0x5A; no data_req_o raised.
- Overlapping ranges (slave 0 and slave 2 both cover 0x100) → request goes to slave 0 only.
- rst_n asserted while 3 transactions are outstanding → all counters 0 and outputs 0 immediately. A late slave response after reset produces no r_valid_o.
